// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC serial capture front end.
// Optional build macro: ADC_STATUS_EN (8-bit status byte appended to each frame).
package adc_pkg;

    // Capture sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        DONE
    } adc_state_t;

    // Trailing status byte layout (only transmitted when ADC_STATUS_EN is defined).
    localparam int STATUS_W       = 8;
    localparam int STATUS_ERR_BIT = 7;

    // Number of serial bits clocked out of the ADC per conversion.
    function automatic int frame_bits(input int dw);
`ifdef ADC_STATUS_EN
        return dw + STATUS_W;
`else
        return dw;
`endif
    endfunction

endpackage

// File: rtl/adc_serial_rx_sync_fall_det.sv
// Multi-flop synchronizer for an asynchronous active-low strobe, followed by a
// registered falling-edge detector. fall_o is a single-cycle pulse.
module sync_fall_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("sync_fall_det: SYNC_STAGES must be >= 2");
    end

    // Synchronize the input, remember the last synchronized level, flag 1->0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // The strobe idles high, so the chain starts high: leaving reset
            // with the line idle must not look like a falling edge.
            sync_q <= '1;
            prev_q <= 1'b1;
            fall_o <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value of its neighbour; blocking here would collapse
            // the synchronizer chain into a single stage.
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            fall_o <= prev_q & ~sync_q[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/adc_serial_rx.sv
// Serial capture of two's-complement samples from the delta-sigma ADC.
// This block is bus master: on each DRDY falling edge it asserts chip select,
// clocks out one frame MSB first on sclk_o and presents the word on data_o
// with a one-cycle valid strobe.
// Optional build macro: ADC_STATUS_EN -- frames carry a trailing status byte,
// exposed on status_o; a frame whose ADC-error bit is set produces no valid.
module adc_serial_rx
    import adc_pkg::*;
#(
    parameter int DW          = 24,
    parameter int SCLK_DIV    = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 drdy_n_i,
    input  logic                 sdo_i,
    output logic                 sclk_o,
    output logic                 cs_n_o,
    output logic                 valid,
    output logic signed [DW-1:0] data_o,
    output logic                 overrun
`ifdef ADC_STATUS_EN
    ,
    output logic [STATUS_W-1:0]  status_o
`endif
);

    localparam int FRAME_W = frame_bits(DW);
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int DIV_W   = $clog2(SCLK_DIV);

    if (SCLK_DIV < 2) begin : g_bad_div
        $error("adc_serial_rx: SCLK_DIV must be >= 2");
    end

    adc_state_t         state;
    logic [FRAME_W-1:0] shreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DIV_W-1:0]   div_cnt;
    logic               drdy_fall;
    logic               div_last;

    sync_fall_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_drdy_det (
        .clk     (clk),
        .rst     (rst),
        .async_i (drdy_n_i),
        .fall_o  (drdy_fall)
    );

    // Every timed state lasts exactly SCLK_DIV cycles.
    assign div_last = (div_cnt == DIV_W'(SCLK_DIV - 1));

    // Capture sequencer. Outputs are registered and updated on the transition
    // into a state, so they are valid for the whole cycle spent in that state
    // (e.g. valid, data_o and cs_n_o=1 appear together in the DONE cycle).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sclk_o  <= 1'b0;
            cs_n_o  <= 1'b1;
            valid   <= 1'b0;
            data_o  <= '0;
            overrun <= 1'b0;
            // NOTE: the shift register is cleared too so an aborted frame
            // leaves no stale partial word behind; a plain data register with
            // no control role could normally skip reset.
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
`ifdef ADC_STATUS_EN
            status_o <= '0;
`endif
        end else begin
            valid   <= 1'b0;
            // A new edge arriving while a frame is in flight (DONE included)
            // is reported and dropped; the running frame is not disturbed.
            overrun <= drdy_fall && (state != IDLE);

            case (state)
                IDLE: begin
                    if (drdy_fall) begin
                        state   <= SETUP;
                        cs_n_o  <= 1'b0;
                        bit_cnt <= '0;
                        div_cnt <= '0;
                    end
                end

                SETUP: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        sclk_o  <= 1'b1;
                        state   <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                SHIFT_HI: begin
                    if (div_last) begin
                        // Sample just before sclk_o falls; the ADC only
                        // changes sdo_i after that falling edge, and since
                        // both are timed by our clock no synchronizer is needed.
                        shreg   <= {shreg[FRAME_W-2:0], sdo_i};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        div_cnt <= '0;
                        sclk_o  <= 1'b0;
                        state   <= SHIFT_LO;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                SHIFT_LO: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        if (bit_cnt < CNT_W'(FRAME_W)) begin
                            sclk_o <= 1'b1;
                            state  <= SHIFT_HI;
                        end else begin
                            cs_n_o <= 1'b1;
                            state  <= DONE;
`ifdef ADC_STATUS_EN
                            status_o <= shreg[STATUS_W-1:0];
                            if (!shreg[STATUS_ERR_BIT]) begin
                                valid  <= 1'b1;
                                data_o <= shreg[FRAME_W-1 -: DW];
                            end
`else
                            valid  <= 1'b1;
                            data_o <= shreg;
`endif
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_serial_rx.sv
// Self-checking bench for adc_serial_rx: table-driven frames, hand-written
// bus-timing / overrun / reset sequences, random samples and a sine stream,
// all checked against an ADC model and expected values computed here.
`timescale 1ns/1ps
module tb_adc_serial_rx;

    localparam int DW          = 24;
    localparam int SCLK_DIV    = 2;
    localparam int SYNC_STAGES = 2;
`ifdef ADC_STATUS_EN
    localparam bit ST_EN = 1'b1;
    localparam int FW    = DW + 8;
`else
    localparam bit ST_EN = 1'b0;
    localparam int FW    = DW;
`endif
    // DRDY driven low in cycle t is detected in cycle t + DET.
    localparam int DET    = SYNC_STAGES + 1;
    // Detect cycle to valid cycle: chip-select setup plus FW full sclk periods.
    localparam int LAT    = 1 + SCLK_DIV + 2 * SCLK_DIV * FW;
    localparam int PERIOD = 195;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 drdy_n_i;
    logic                 sdo_i;
    logic                 sclk_o;
    logic                 cs_n_o;
    logic                 valid;
    logic signed [DW-1:0] data_o;
    logic                 overrun;
`ifdef ADC_STATUS_EN
    logic [7:0]           status_o;
`endif

    adc_serial_rx #(
        .DW          (DW),
        .SCLK_DIV    (SCLK_DIV),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .drdy_n_i (drdy_n_i),
        .sdo_i    (sdo_i),
        .sclk_o   (sclk_o),
        .cs_n_o   (cs_n_o),
        .valid    (valid),
        .data_o   (data_o),
        .overrun  (overrun)
`ifdef ADC_STATUS_EN
        ,
        .status_o (status_o)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ADC model: latches the word while deselected, presents the MSB once
    // selected and advances one bit after every sclk_o falling edge.
    logic [FW-1:0] adc_word = '0;
    logic [FW-1:0] word_l   = '0;
    int            idx      = 0;
    logic          sclk_d   = 1'b0;
    always @(negedge clk) begin
        if (cs_n_o) begin
            idx    = 0;
            word_l = adc_word;
        end else if (sclk_d && !sclk_o) begin
            idx = idx + 1;
        end
        sclk_d = sclk_o;
    end
    assign sdo_i = (idx < FW) ? word_l[FW-1-idx] : 1'b0;

    // Output monitor, sampled mid-cycle.
    int                   vq_cyc[$];
    logic signed [DW-1:0] vq_dat[$];
    int                   oq_cyc[$];
    int                   consec  = 0;
    logic                 valid_d = 1'b0;
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            vq_cyc.push_back(cyc);
            vq_dat.push_back(data_o);
            if (valid_d) consec++;
        end
        if (overrun === 1'b1) oq_cyc.push_back(cyc);
        valid_d = (valid === 1'b1);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Drive a DRDY low pulse starting just after a rising edge; t = its cycle.
    task automatic drdy_pulse(input int low_len, output int t);
        @(posedge clk);
        #1;
        drdy_n_i = 1'b0;
        t = cyc;
        repeat (low_len) @(posedge clk);
        #1;
        drdy_n_i = 1'b1;
    endtask

    // Return mid-cycle once cycle c has been sampled by the monitor.
    task automatic settle_until(input int c);
        wait (cyc >= c);
        @(negedge clk);
        #1;
    endtask

    function automatic void clear_q();
        vq_cyc.delete();
        vq_dat.delete();
        oq_cyc.delete();
    endfunction

    int                   model_data = 0;
    int                   prev_vcyc  = -1;
    logic signed [DW-1:0] last_cap   = '0;

    // One full conversion; the next frame's DRDY falls exactly gap cycles later.
    task automatic run_frame(input string name, input logic [DW-1:0] sample,
                             input logic [7:0] status, input bit exp_valid,
                             input int exp_data, input int gap, input bit chk_period);
        logic [DW+7:0] full;
        int            t;
        full     = {sample, status};
        adc_word = full[DW+7 -: FW];
        clear_q();
        drdy_pulse(4, t);
        settle_until(t + gap - 1);
        if (exp_valid) begin
            check({name, " valid count"}, vq_cyc.size(), 1);
            if (vq_cyc.size() > 0) begin
                check({name, " valid cycle"}, vq_cyc[0], t + DET + LAT);
                check({name, " data"}, vq_dat[0], exp_data);
                if (chk_period && prev_vcyc >= 0)
                    check({name, " valid period"}, vq_cyc[0] - prev_vcyc, PERIOD);
                prev_vcyc = vq_cyc[0];
                last_cap  = vq_dat[0];
            end
            model_data = exp_data;
        end else begin
            check({name, " suppressed valid"}, vq_cyc.size(), 0);
            check({name, " data held"}, data_o, model_data);
            prev_vcyc = -1;
        end
        check({name, " overrun"}, oq_cyc.size(), 0);
`ifdef ADC_STATUS_EN
        check({name, " status"}, status_o, status);
`endif
    endtask

    typedef struct {
        logic [DW-1:0] word;
        logic [7:0]    status;
        bit            exp_valid;
        int            exp_data;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int t1, t2, ocnt, rises, cs_err, sclk_err, s, u, xings;
        bit neg_prev;
        logic sclk_p;

        tbl[0] = '{24'h7FFFFF, 8'h00, 1'b1,    8388607};
        tbl[1] = '{24'h800000, 8'h80, !ST_EN, -8388608};
        tbl[2] = '{24'h000001, 8'h00, 1'b1,    1};
        tbl[3] = '{24'h000000, 8'h01, 1'b1,    0};
        tbl[4] = '{24'hFFFFFF, 8'h7F, 1'b1,   -1};
        tbl[5] = '{24'h555555, 8'h00, 1'b1,    5592405};
        tbl[6] = '{24'hAAAAAA, 8'h00, 1'b1,   -5592406};

        rst      = 1'b1;
        drdy_n_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset sclk_o", sclk_o, 0);
        check("reset cs_n_o", cs_n_o, 1);
        check("reset valid", valid, 0);
        check("reset data_o", data_o, 0);
        check("reset overrun", overrun, 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // Table-driven frames, DRDY every 195 cycles.
        prev_vcyc = -1;
        for (int i = 0; i < 7; i++)
            run_frame($sformatf("tbl%0d", i), tbl[i].word, tbl[i].status,
                      tbl[i].exp_valid, tbl[i].exp_data, PERIOD, 1'b1);

        // Bus timing of one frame, compared cycle by cycle with the ideal waveform.
        adc_word = FW'(32'h00C0FFEE);
        clear_q();
        drdy_pulse(1, t1);
        rises = 0; cs_err = 0; sclk_err = 0; sclk_p = 1'b0;
        for (int k = t1 + DET; k <= t1 + DET + LAT + 2; k++) begin
            int  rel;
            bit  exp_sclk;
            wait (cyc >= k);
            @(negedge clk);
            #1;
            rel      = k - (t1 + DET + 1 + SCLK_DIV);
            exp_sclk = (rel >= 0) && (rel < 2 * SCLK_DIV * FW) && ((rel % (2 * SCLK_DIV)) < SCLK_DIV);
            if (sclk_o !== exp_sclk) sclk_err++;
            if (cs_n_o !== !((k >= t1 + DET + 1) && (k <= t1 + DET + LAT - 1))) cs_err++;
            if (sclk_o && !sclk_p) rises++;
            sclk_p = sclk_o;
        end
        check("bus sclk rising edges", rises, FW);
        check("bus sclk waveform errors", sclk_err, 0);
        check("bus cs_n window errors", cs_err, 0);
        check("bus valid cycle", (vq_cyc.size() == 1) ? vq_cyc[0] : -1, t1 + DET + LAT);
        settle_until(t1 + PERIOD);
        model_data = 32'sh00C0FFEE >>> (FW - DW);
        model_data = (model_data >= 8388608) ? model_data - 16777216 : model_data;

        // Overrun: second DRDY 50 cycles into the frame.
        adc_word = {24'h123456, {(FW-DW){1'b0}}};
        clear_q();
        drdy_pulse(4, t1);
        settle_until(t1 + 49);
        adc_word = {24'h654321, {(FW-DW){1'b0}}};
        drdy_pulse(4, t2);
        settle_until(t1 + DET + LAT + 150);
        check("ovr pulse count", oq_cyc.size(), 1);
        if (oq_cyc.size() > 0)
            check("ovr pulse timing", (oq_cyc[0] >= t2 + DET) && (oq_cyc[0] <= t2 + DET + 1), 1);
        check("ovr valid count", vq_cyc.size(), 1);
        if (vq_cyc.size() > 0) begin
            check("ovr valid cycle", vq_cyc[0], t1 + DET + LAT);
            check("ovr first sample", vq_dat[0], 24'h123456);
        end
        check("ovr no second frame", cs_n_o, 1);

        // Overrun on a DRDY detected in the DONE cycle itself.
        adc_word = {24'h0ABCDE, {(FW-DW){1'b0}}};
        clear_q();
        drdy_pulse(4, t1);
        settle_until(t1 + LAT - 1);
        drdy_pulse(4, t2);
        settle_until(t1 + DET + LAT + 150);
        check("done-ovr pulse count", oq_cyc.size(), 1);
        check("done-ovr valid count", vq_cyc.size(), 1);

        // DRDY held low for several frame times triggers only once.
        clear_q();
        drdy_pulse(400, t1);
        settle_until(t1 + 420);
        check("held-low valid count", vq_cyc.size(), 1);
        check("held-low overrun count", oq_cyc.size(), 0);
        model_data = 24'h0ABCDE;
        check("held-low data", data_o, model_data);

        // Reset 40 cycles into a frame.
        adc_word = {24'h7654AB, {(FW-DW){1'b0}}};
        clear_q();
        drdy_pulse(4, t1);
        wait (cyc >= t1 + DET + 40);
        #1;
        rst = 1'b1;
        #1;
        check("midrst sclk_o", sclk_o, 0);
        check("midrst cs_n_o", cs_n_o, 1);
        check("midrst valid", valid, 0);
        check("midrst data_o", data_o, 0);
        check("midrst overrun", overrun, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_data = 0;
        settle_until(t1 + DET + LAT + 20);
        check("midrst aborted frame valid", vq_cyc.size(), 0);
        prev_vcyc = -1;
        run_frame("post-reset", 24'h3C3C3C, 8'h00, 1'b1, 3947580, PERIOD, 1'b0);

        // Random samples and status bytes with irregular DRDY spacing.
        for (int i = 0; i < 6; i++) begin
            logic [7:0] st;
            s  = int'($urandom);
            st = 8'($urandom_range(0, 255));
            u  = s & 32'h00FF_FFFF;
            run_frame($sformatf("rand%0d", i), s[DW-1:0], st, !(ST_EN && st[7]),
                      (u >= 8388608) ? u - 16777216 : u,
                      PERIOD + int'($urandom_range(0, 30)), 1'b0);
        end

        // 10 kHz sine sampled at 512 kHz; 64 samples span about 1.25 periods,
        // so the captured stream must change sign exactly twice.
        prev_vcyc = -1;
        xings     = 0;
        neg_prev  = 1'b0;
        for (int n = 0; n < 64; n++) begin
            s = $rtoi(8000000.0 * $sin(2.0 * 3.14159265358979 * 10000.0 * n / 512000.0));
            run_frame($sformatf("sine%0d", n), s[DW-1:0], 8'h00, 1'b1, s, PERIOD, 1'b1);
            if (n > 0 && ((last_cap < 0) != neg_prev)) xings++;
            neg_prev = (last_cap < 0);
        end
        check("sine sign changes", xings, 2);

        check("no back-to-back valid", consec, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adc_serial_rx.md
Name: adc_serial_rx

Overview:
- Front-end capture stage for the LPDAQ decimation chain.
- Reads 24-bit two's-complement samples from the external delta-sigma ADC over a DRDY-triggered serial interface. The block is clock master.
- Presents each sample as a one-cycle valid strobe plus data word.
- Its valid/data_o outputs drive the down-sampler's en512000/data_i inputs directly, at about 512 kHz.

Parameters:
DW, 24, sample width in bits, shifted MSB first
SCLK_DIV, 2, sclk half-period in clk cycles; must be ≥2
SYNC_STAGES, 2, synchronizer depth on drdy_n_i; must be ≥2

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  asynchronous, active-high reset
drdy_n_i  input  1  ADC data-ready, asynchronous, falling edge = new sample
sdo_i  input  1  ADC serial data; changes after sclk_o falling edge
sclk_o  output  1  serial clock to ADC, idles low
cs_n_o  output  1  ADC chip select, active low
valid  output  1  one-cycle strobe: data_o holds a new sample
data_o  output  DW  signed sample, held until next valid
overrun  output  1  one-cycle pulse: a DRDY edge was dropped

Behaviour:
- Reset (async, rst=1): state=IDLE, sclk_o=0, cs_n_o=1, valid=0, data_o=0, overrun=0, shift register and bit counter=0. Reset mid-frame aborts the frame and produces no valid.
- drdy_n_i passes through SYNC_STAGES flops. A falling edge is detected one cycle after the synchronized value goes 1→0. Call that detect cycle T.
- FSM states: IDLE, SETUP, SHIFT_HI, SHIFT_LO, DONE.
  - IDLE: on detect, go to SETUP and drive cs_n_o=0 from T+1.
  - SETUP: hold SCLK_DIV cycles with sclk_o=0, then go to SHIFT_HI.
  - SHIFT_HI: sclk_o=1 for SCLK_DIV cycles. On the last of those cycles, shift sdo_i into the LSB of the shift register (shift left) and increment the bit counter. Then go to SHIFT_LO.
  - SHIFT_LO: sclk_o=0 for SCLK_DIV cycles. Then go to SHIFT_HI if fewer than DW bits have been taken, else go to DONE.
  - DONE: single cycle. cs_n_o=1, data_o<=shift register, valid=1. Next state is IDLE.
- sdo_i is sampled without a synchronizer, since it is timed by our own sclk_o.
- Latency: valid is asserted at T + 1 + SCLK_DIV + 2·SCLK_DIV·DW. With defaults that is T+99. This frame time must stay below the 195-cycle sample period.
- Overrun: a detect while state≠IDLE pulses overrun for one cycle. The current frame continues unaffected and the edge is discarded; there is no queuing.
- A detect in the same cycle as DONE also counts as an overrun, because the FSM is not yet in IDLE.
- valid is never asserted for two consecutive cycles.
- drdy_n_i held low does not retrigger. Only a new 1→0 transition starts a frame.
- Arithmetic: none. data_o is the raw two's-complement word. The MSB is the first bit received.

Optional Feature:
Macro ADC_STATUS_EN.
- Defined:
  - Each frame is DW+8 bits. The 8 trailing bits form a status byte, and an extra output status_o [7:0] is updated in DONE.
  - If status bit 7 (ADC error) is 1, valid is suppressed for that frame and data_o keeps its previous value. status_o is still updated.
  - Latency grows by 16·SCLK_DIV cycles.
- Undefined: the status_o port is absent, frames are exactly DW bits, and behaviour is as above.

Decomposition:
- Package adc_pkg holds:
  - enum adc_state_t {IDLE, SETUP, SHIFT_HI, SHIFT_LO, DONE}
  - localparam STATUS_W=8
  - localparam STATUS_ERR_BIT=7
- One sub-module, sync_fall_det: parameter SYNC_STAGES, ports clk/rst/async_i/fall_o. It contains the synchronizer chain and the falling-edge detector. The FSM, dividers and shift register stay in adc_serial_rx.

Test Plan:
- Sample capture: bench ADC model returns 24'h7FFFFF, then 24'h800000, then 24'h000001 on three DRDY falls spaced 195 cycles apart. Required: three valid pulses, each at T+99, with data_o = +8388607, −8388608, +1; no overrun.
- Bus timing: one frame with defaults. Required: exactly 24 sclk_o rising edges, sclk_o high 2 cycles and low 2 cycles each, cs_n_o low from T+1 through T+98, high at T+99.
- Overrun: second DRDY fall 50 cycles after the first. Required: one overrun pulse, only one valid at T+99 carrying the first sample, no second frame started.
- Reset mid-frame: rst=1 at T+40 for 3 cycles, then a new DRDY fall. Required: outputs are at reset values immediately, with no valid for the aborted frame. The next frame captures correctly.
- Sine stream: ADC model streams a 10 kHz sine at 512 kHz into the down-sampler. Required: 195-cycle valid period, no overrun, and the down-sampler output shows a 10 kHz tone.
- ADC_STATUS_EN defined: status 8'h80 on the second frame. Required: no valid for that frame, data_o unchanged, status_o=8'h80; first and third frames produce valid at T+131.
